// File: rtl/regfile_pkg.sv
// regfile_pkg: parameters and types shared by the integer register file
// and its write-back unit.
//   XLEN       - data width of a register
//   NREG       - number of architectural registers
//   AW         - register address width (log2 NREG)
//   FIFO_DEPTH - entries in the write-back load buffer
//   CW         - width of the load buffer occupancy counter
package regfile_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned NREG       = 32;
  localparam int unsigned AW         = 5;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);

  typedef logic [AW-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/wb_fifo.sv
// wb_fifo: two-entry buffer of {rd, data} for load results that lost
// write-port arbitration.
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   push_i               - write push_rd_i/push_data_i into the tail
//   push_rd_i/_data_i    - entry being pushed
//   pop_i                - drop the head entry
//   head_rd_o/_data_o    - current head entry (valid when !empty_o)
//   count_o              - number of occupied entries
//   full_o, empty_o      - occupancy flags
// The caller never pushes while full nor pops while empty.
module wb_fifo
  import regfile_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [AW-1:0]   push_rd_i,
  input  logic [XLEN-1:0] push_data_i,
  input  logic            pop_i,
  output logic [AW-1:0]   head_rd_o,
  output logic [XLEN-1:0] head_data_o,
  output logic [CW-1:0]   count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [AW-1:0]   rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];

  // Depth is two, so a single bit addresses each slot.
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      rd_mem[wr_ptr_q]   <= push_rd_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_rd_o   = rd_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(FIFO_DEPTH));
  assign empty_o     = (count_q == '0);

endmodule : wb_fifo

// File: rtl/regfile_wb.sv
// regfile_wb: sole writer of the integer register file write port.
//   clk, rst (async, active-low)
//   issue_en/issue_rd         - instruction with destination issues; marks it busy
//   alu_valid/alu_rd/alu_data - single-cycle ALU result, never back-pressured
//   lsu_valid/lsu_ready/lsu_rd/lsu_data - load result handshake
//   wr_en/wr_addr/wr_data     - registered register-file write
//   busy                      - per-register pending-write scoreboard
// Handshake: a load transfers on any rising edge where lsu_valid && lsu_ready;
// the LSU holds rd/data stable while valid and not ready. lsu_ready depends
// only on buffer occupancy, never on lsu_valid.
// Priority each cycle: ALU, then buffered load, then direct load bypass.
module regfile_wb
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [NREG-1:0] busy
);

  reg_addr_t       head_rd;
  logic [XLEN-1:0] head_data;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;

  logic            lsu_fire, push, pop;
  logic            sel_valid;
  reg_addr_t       sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            wr_en_q, wr_en_d;
  reg_addr_t       wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign lsu_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign lsu_fire  = lsu_valid && lsu_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    push      = 1'b0;
    pop       = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
      push      = lsu_fire && !fifo_full;
    end else if (!fifo_empty) begin
      // Buffered loads drain before a new load so acceptance order holds.
      sel_valid = 1'b1;
      sel_rd    = head_rd;
      sel_data  = head_data;
      pop       = 1'b1;
      push      = lsu_fire && !fifo_full;
    end else if (lsu_fire) begin
      sel_valid = 1'b1;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
    end
  end

  always_comb begin
    // x0 results are consumed but never reach the register file.
    wr_en_d   = sel_valid && (sel_rd != '0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (sel_valid) begin
      wr_addr_d = sel_rd;
      wr_data_d = sel_data;
    end
    // Clear for the retiring write first, then set for the new issue so
    // a same-cycle collision leaves the newer instruction pending.
    busy_d = busy_q;
    if (sel_valid) busy_d[sel_rd] = 1'b0;
    if (issue_en && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  wb_fifo u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_rd_i   (lsu_rd),
    .push_data_i (lsu_data),
    .pop_i       (pop),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule : regfile_wb

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;
  import regfile_pkg::*;

  localparam int EW = AW + XLEN;

  logic            clk;
  logic            rst;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [NREG-1:0] busy;

  regfile_wb dut (
    .clk       (clk),
    .rst       (rst),
    .issue_en  (issue_en),
    .issue_rd  (issue_rd),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model / scoreboard ----------------
  // m_buf: loads accepted but not yet written, oldest first.
  // exp_q: writes the register file must see, in order.
  logic [EW-1:0]   m_buf[$];
  logic [EW-1:0]   exp_q[$];
  logic [NREG-1:0] m_busy;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_buf.delete();
    exp_q.delete();
    m_busy = '0;
  endtask

  // One clock: apply the write-back rules to the inputs present before the
  // edge, advance the model, then compare the DUT just after the edge.
  // acc reports whether the DUT took the offered load.
  task automatic step(output bit acc);
    bit            take, sel;
    logic [EW-1:0] ent;
    logic [EW-1:0] got;
    chk("lsu_ready", lsu_ready, (m_buf.size() < FIFO_DEPTH) ? 1 : 0);
    acc  = lsu_valid && lsu_ready;
    take = lsu_valid && (m_buf.size() < FIFO_DEPTH);
    sel  = 1'b0;
    ent  = '0;
    if (alu_valid) begin
      sel = 1'b1;
      ent = {alu_rd, alu_data};
      if (take) m_buf.push_back({lsu_rd, lsu_data});
    end else if (m_buf.size() > 0) begin
      sel = 1'b1;
      ent = m_buf.pop_front();
      if (take) m_buf.push_back({lsu_rd, lsu_data});
    end else if (take) begin
      sel = 1'b1;
      ent = {lsu_rd, lsu_data};
    end
    if (sel) m_busy[ent[EW-1:XLEN]] = 1'b0;
    if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (sel && ent[EW-1:XLEN] != 0) exp_q.push_back(ent);
    @(posedge clk);
    #1;
    chk("busy", busy, m_busy);
    chk("wr_en", wr_en, (sel && ent[EW-1:XLEN] != 0) ? 1 : 0);
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        got = exp_q.pop_front();
        chk("wr_addr", wr_addr, got[EW-1:XLEN]);
        chk("wr_data", wr_data, got[XLEN-1:0]);
      end
    end else if (sel && ent[EW-1:XLEN] != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    issue_en  = 1'b0;
    issue_rd  = '0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_rd    = '0;
    lsu_data  = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_lsu_ready"}, lsu_ready, 1);
  endtask

  task automatic drive_alu(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic drive_lsu(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    lsu_valid = 1'b1;
    lsu_rd    = rd;
    lsu_data  = d;
  endtask

  task automatic drive_issue(input logic [AW-1:0] rd);
    issue_en = 1'b1;
    issue_rd = rd;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit acc;
    int loads;
    bit lsu_pend;
    rst = 1'b0;
    idle_inputs();
    model_clear();
    #1;
    check_reset_values("in_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) step(acc);
    check_reset_values("idle");

    // issue x5, ALU writes x5 = 0xDEAD one cycle later.
    drive_issue(5'd5);
    step(acc);
    idle_inputs();
    chk("busy5_set", busy[5], 1);
    drive_alu(5'd5, 64'hDEAD);
    step(acc);
    chk("alu_wr_en", wr_en, 1);
    chk("alu_wr_addr", wr_addr, 5);
    chk("alu_wr_data", wr_data, 64'hDEAD);
    chk("busy5_clear", busy[5], 0);
    idle_inputs();

    // ALU and LSU together: x3 now, x4 one cycle later.
    drive_alu(5'd3, 64'h11);
    drive_lsu(5'd4, 64'h22);
    step(acc);
    chk("both_acc", acc, 1);
    chk("both_first_addr", wr_addr, 3);
    idle_inputs();
    step(acc);
    chk("both_second_en", wr_en, 1);
    chk("both_second_addr", wr_addr, 4);
    chk("both_second_data", wr_data, 64'h22);
    step(acc);
    chk("both_drained", wr_en, 0);

    // ALU held 4 cycles while 3 loads are offered.
    loads = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive_alu(5'(10 + c), 64'hA000 + 64'(c));
      else alu_valid = 1'b0;
      if (loads < 3) drive_lsu(5'(20 + loads), 64'hB000 + 64'(loads));
      else lsu_valid = 1'b0;
      step(acc);
      if (acc) loads++;
      if (c == 1) chk("full_ready_low", lsu_ready, 0);
      if (c == 4) chk("first_pop_addr", wr_addr, 20);
      if (c == 4) chk("ready_back_after_pop", lsu_ready, 1);
    end
    chk("three_loads_taken", loads, 3);
    idle_inputs();

    // x0 write is dropped, x0 never becomes busy.
    drive_alu(5'd0, 64'hFFFF);
    drive_issue(5'd0);
    step(acc);
    chk("x0_wr_en", wr_en, 0);
    chk("x0_busy", busy[0], 0);
    idle_inputs();

    // Re-issue of x7 in the cycle its older write retires keeps it busy.
    drive_issue(5'd7);
    step(acc);
    drive_alu(5'd7, 64'h7777);
    step(acc);
    chk("x7_wr_en", wr_en, 1);
    chk("x7_wr_addr", wr_addr, 7);
    chk("x7_busy_kept", busy[7], 1);
    idle_inputs();
    step(acc);

    // Random traffic with an asynchronous reset in the middle.
    lsu_pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("mid_reset");
        model_clear();
        idle_inputs();
        lsu_pend = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      alu_valid = ($urandom_range(0, 99) < 45);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = {$urandom, $urandom};
      issue_en  = ($urandom_range(0, 1) == 1);
      issue_rd  = 5'($urandom_range(0, 31));
      if (!lsu_pend) begin
        lsu_valid = ($urandom_range(0, 99) < 60);
        lsu_rd    = 5'($urandom_range(0, 31));
        lsu_data  = {$urandom, $urandom};
      end
      step(acc);
      lsu_pend = lsu_valid && !acc;
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step(acc);
    chk("final_queue_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb
